hysteresis_thresh: RTL

Double-threshold and hysteresis stage of the Canny edge pipeline, placed directly downstream of non-maximum suppression. Consumes the suppressed-magnitude raster stream one pixel per accepted cycle. Classifies each pixel as strong, weak or none, and buffers two rows of classes to form a 3x3 neighbourhood. Emits a binary edge map in raster order: strong pixels are edges, and weak pixels with at least one strong 8-neighbour are edges.

---
 rtl/canny_pkg.sv | 8 +
 rtl/hyst_line_buffer.sv | 31 +++
 rtl/hysteresis_thresh.sv | 125 ++++++++++++
 3 files changed

// File: rtl/canny_pkg.sv
// canny_pkg: shared defaults, pixel class and FSM state encodings for the Canny pipeline
package canny_pkg;
  localparam int BIT_LENGTH_DEF = 5;
  localparam int IMG_WIDTH_DEF = 960;
  localparam int IMG_HEIGHT_DEF = 720;
  typedef enum logic [1:0] {NONE = 2'd0, WEAK = 2'd1, STRONG = 2'd2} class_t;
  typedef enum logic [2:0] {IDLE, FILL, RUN, FLUSH, DONE} state_t;
endpackage

// File: rtl/hyst_line_buffer.sv
// hyst_line_buffer: two W-deep circular rows of pixel classes; col = {two rows up, one row up, incoming}
module hyst_line_buffer
  import canny_pkg::*;
#(
  parameter int W = IMG_WIDTH_DEF
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   shift,
  input  class_t din,
  output class_t col [3]
);
  localparam int PW = $clog2(W);
  class_t mem1 [W];
  class_t mem2 [W];
  logic [PW-1:0] ptr;
  assign col[0] = din;
  assign col[1] = mem1[ptr];
  assign col[2] = mem2[ptr];
  // contents are never reset: stale entries are masked by the border counters downstream
  always_ff @(posedge clk) begin
    if (shift) begin
      mem1[ptr] <= din;
      mem2[ptr] <= mem1[ptr];
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ptr <= '0;
    else if (shift) ptr <= (ptr == PW'(W - 1)) ? '0 : ptr + 1'b1;
  end
endmodule

// File: rtl/hysteresis_thresh.sv
// hysteresis_thresh: double threshold + 8-neighbour hysteresis to a binary edge map.
// Define HYST_STATS_EN to build the per-frame edge counter behind edge_count.
module hysteresis_thresh
  import canny_pkg::*;
#(
  parameter int IMG_WIDTH = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
  parameter int BIT_LENGTH = BIT_LENGTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [BIT_LENGTH-1:0] pixel_in,
  input  logic [BIT_LENGTH-1:0] th_low,
  input  logic [BIT_LENGTH-1:0] th_high,
  output logic                  out_valid,
  output logic [BIT_LENGTH-1:0] pixel_out,
  output logic                  frame_done,
  output logic [19:0]           edge_count
);
  localparam int W = IMG_WIDTH;
  localparam int H = IMG_HEIGHT;
  localparam int N = W * H;
  localparam int IW = $clog2(N + 1);
  localparam int CW = $clog2(W);
  localparam int RW = $clog2(H);
  state_t state;
  logic [IW-1:0] idx;
  logic [CW-1:0] cc;
  logic [RW-1:0] cr;
  logic [BIT_LENGTH-1:0] tl, th, lo, hi;
  class_t c_in, col [3], wl [3], wc [3];
  logic accept, flush, adv, emit, last, lt, rt, up_ok, dn_ok, nb, edge_px;
  // window columns: wl = left, wc = center, col = right (entering); row 0 below, 1 center, 2 above
  always_comb begin
    accept = in_valid && (state == IDLE || state == FILL || state == RUN);
    flush = state == FLUSH;
    adv = accept || flush;
    emit = (state == RUN && in_valid) || flush;
    lo = state == IDLE ? th_low : tl;
    hi = state == IDLE ? th_high : th;
    c_in = flush ? NONE : pixel_in >= hi ? STRONG : pixel_in >= lo ? WEAK : NONE;
    lt = cc != '0;
    rt = cc != CW'(W - 1);
    up_ok = cr != '0;
    dn_ok = cr != RW'(H - 1);
    last = !rt && !dn_ok;
    nb = (up_ok && (wc[2] == STRONG || lt && wl[2] == STRONG || rt && col[2] == STRONG))
      || (lt && wl[1] == STRONG) || (rt && col[1] == STRONG)
      || (dn_ok && (wc[0] == STRONG || lt && wl[0] == STRONG || rt && col[0] == STRONG));
    edge_px = wc[1] == STRONG || (wc[1] == WEAK && nb);
  end
  hyst_line_buffer #(.W(W)) u_lb (
    .clk(clk),
    .reset(reset),
    .shift(adv),
    .din(c_in),
    .col(col)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wl <= '{default: NONE};
      wc <= '{default: NONE};
    end else if (adv) begin
      wl <= wc;
      wc <= col;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      idx <= '0;
      cc <= '0;
      cr <= '0;
      tl <= '0;
      th <= '0;
      out_valid <= 1'b0;
      pixel_out <= '0;
      frame_done <= 1'b0;
    end else begin
      out_valid <= emit;
      pixel_out <= {BIT_LENGTH{emit && edge_px}};
      frame_done <= emit && last;
      if (emit) begin
        cc <= rt ? cc + 1'b1 : '0;
        cr <= last ? '0 : rt ? cr : cr + 1'b1;
      end
      case (state)
        IDLE: if (in_valid) begin
          state <= FILL;
          idx <= IW'(1);
          tl <= th_low;
          th <= th_high;
        end
        FILL: if (in_valid) begin
          idx <= idx + 1'b1;
          if (idx == IW'(W)) state <= RUN;
        end
        RUN: if (in_valid) begin
          idx <= idx == IW'(N - 1) ? '0 : idx + 1'b1;
          if (idx == IW'(N - 1)) state <= FLUSH;
        end
        FLUSH: begin
          idx <= idx == IW'(W) ? '0 : idx + 1'b1;
          if (idx == IW'(W)) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef HYST_STATS_EN
  logic [19:0] ecnt;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ecnt <= '0;
      edge_count <= '0;
    end else if (emit) begin
      ecnt <= last ? '0 : ecnt + 20'(edge_px);
      if (last) edge_count <= ecnt + 20'(edge_px);
    end
  end
`else
  assign edge_count = '0;
`endif
endmodule
